// File: rtl/resp_pkg.sv
// Shared types for the response RAM readout block.
package resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DONE  = 2'd3
    } resp_state_t;

endpackage

// File: rtl/resp_readout.sv
// Drains a window of the response RAM onto a valid/ready stream, one word per
// RAM read, with a completion pulse and busy flag for the sequencer.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// FETCH | address presented, waiting out the RAM read latency
// HOLD  | word presented on m_data, waiting for m_ready
// DONE  | one-cycle done pulse, then back to IDLE
module resp_readout
    import resp_pkg::*;
#(
    parameter int N_RESPONSE_BITS_PER_WORD = 2,
    parameter int N_RESPONSE_WORDS         = 8,
    parameter int READ_LATENCY             = 2,
    localparam int RESP_ADDR_WIDTH         = $clog2(N_RESPONSE_WORDS)
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                start,
    input  logic [RESP_ADDR_WIDTH:0]            n_words,
    output logic [RESP_ADDR_WIDTH-1:0]          resp_addr,
    input  logic [N_RESPONSE_BITS_PER_WORD-1:0] resp_rdata,
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic [N_RESPONSE_BITS_PER_WORD-1:0] m_data,
    output logic                                m_last,
    output logic                                busy,
    output logic                                done
);

    localparam int WAIT_W = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
    localparam logic [WAIT_W-1:0]          WAIT_LAST = WAIT_W'(READ_LATENCY);
    localparam logic [RESP_ADDR_WIDTH:0]   MAX_WORDS = (RESP_ADDR_WIDTH + 1)'(N_RESPONSE_WORDS);
    localparam logic [RESP_ADDR_WIDTH:0]   ONE_WORD  = (RESP_ADDR_WIDTH + 1)'(1);

    resp_state_t                state;
    logic [WAIT_W-1:0]          wait_cnt;
    logic [RESP_ADDR_WIDTH:0]   words_left;
    logic [RESP_ADDR_WIDTH:0]   n_clamped;

    always_comb begin
        n_clamped = (n_words > MAX_WORDS) ? MAX_WORDS : n_words;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            resp_addr  <= '0;
            wait_cnt   <= '0;
            words_left <= '0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_last     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        resp_addr  <= '0;
                        wait_cnt   <= '0;
                        words_left <= n_clamped;
                        busy       <= 1'b1;
                        if (n_clamped == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    // Capture on the edge after the RAM q reflects resp_addr.
                    if (wait_cnt == WAIT_LAST) begin
                        wait_cnt <= '0;
                        m_data   <= resp_rdata;
                        m_last   <= (words_left == ONE_WORD);
                        m_valid  <= 1'b1;
                        state    <= ST_HOLD;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        if (words_left == ONE_WORD) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            resp_addr  <= resp_addr + 1'b1;
                            words_left <= words_left - 1'b1;
                            state      <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
